// File: rtl/fp_operand_stage.sv
// fp_operand_stage: operand FIFO in front of an FP adder/subtractor.
// Each operand pair is classified as it is pushed, so special cases
// (NaN, Inf, zero) are resolved here and bypass the adder.
// The resolved flag and result are stored with the entry.
// The head entry is driven to out_* straight from storage.
// special_count is a saturating count of special entries that have been
// dequeued.
module fp_operand_stage #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_op,
  output logic             out_special,
  output logic [WIDTH-1:0] out_special_result,
  output logic [15:0]      special_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   special_count_q, special_count_d;

  // Entry storage is deliberately not reset; an empty FIFO masks it.
  logic [WIDTH-1:0] a_mem   [DEPTH];
  logic [WIDTH-1:0] b_mem   [DEPTH];
  logic             op_mem  [DEPTH];
  logic             sp_mem  [DEPTH];
  logic [WIDTH-1:0] res_mem [DEPTH];

  logic             push, pop;
  logic             cls_special;
  logic [WIDTH-1:0] cls_result;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Classify the incoming pair; b's sign is folded with the operation
  // so a-b is treated as a+(-b).
  always_comb begin
    logic             sb_eff;
    logic [WIDTH-1:0] b_eff;
    logic             a_exp_ones, b_exp_ones, a_mant_nz, b_mant_nz;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    sb_eff      = in_b[WIDTH-1] ^ in_op;
    b_eff       = {sb_eff, in_b[WIDTH-2:0]};
    a_exp_ones  = &in_a[WIDTH-2 -: EXP_BITS];
    b_exp_ones  = &in_b[WIDTH-2 -: EXP_BITS];
    a_mant_nz   = |in_a[MANT_BITS-1:0];
    b_mant_nz   = |in_b[MANT_BITS-1:0];
    a_nan       = a_exp_ones && a_mant_nz;
    b_nan       = b_exp_ones && b_mant_nz;
    a_inf       = a_exp_ones && !a_mant_nz;
    b_inf       = b_exp_ones && !b_mant_nz;
    // Denormals are flushed: any zero exponent counts as zero.
    a_zero      = ~|in_a[WIDTH-2 -: EXP_BITS];
    b_zero      = ~|in_b[WIDTH-2 -: EXP_BITS];
    cls_special = 1'b1;
    cls_result  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (in_a[WIDTH-1] != sb_eff))) begin
      cls_result = QNAN;
    end else if (a_inf) begin
      cls_result = in_a;
    end else if (b_inf) begin
      cls_result = b_eff;
    end else if (a_zero && b_zero) begin
      cls_result = {in_a[WIDTH-1] & sb_eff, {(WIDTH-1){1'b0}}};
    end else if (a_zero) begin
      cls_result = b_eff;
    end else if (b_zero) begin
      cls_result = in_a;
    end else begin
      cls_special = 1'b0;
    end
  end

  // Next-state for occupancy, pointers and the saturating special counter.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    special_count_d = special_count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
    if (pop && sp_mem[rd_ptr_q] && (special_count_q != 16'hFFFF))
      special_count_d = special_count_q + 16'd1;
  end

  // Control state; reset asynchronously discards every stored entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      special_count_q <= '0;
    end else begin
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      special_count_q <= special_count_d;
    end
  end

  // Entry write on push: raw operands plus the classification outcome.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q]   <= in_a;
      b_mem[wr_ptr_q]   <= in_b;
      op_mem[wr_ptr_q]  <= in_op;
      sp_mem[wr_ptr_q]  <= cls_special;
      res_mem[wr_ptr_q] <= cls_result;
    end
  end

  assign out_a              = a_mem[rd_ptr_q];
  assign out_b              = b_mem[rd_ptr_q];
  assign out_op             = op_mem[rd_ptr_q];
  // Stale storage must not look special while the FIFO is empty.
  assign out_special        = out_valid & sp_mem[rd_ptr_q];
  assign out_special_result = out_valid ? res_mem[rd_ptr_q] : '0;
  assign special_count      = special_count_q;

endmodule

// File: tb/tb_fp_operand_stage.sv
// Testbench for fp_operand_stage: directed vectors, scoreboard queue,
// independent pop monitor.
module tb_fp_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic        out_op;
  logic        out_special;
  logic [31:0] out_special_result;
  logic [15:0] special_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        sp;
    logic [31:0] res;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sc = '0;

  fp_operand_stage #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_special(out_special), .out_special_result(out_special_result),
    .special_count(special_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got out_a=0x%08h, expected empty queue", out_a);
      end else begin
        e = sb_q.pop_front();
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_op", {31'b0, out_op}, {31'b0, e.op});
        chk("out_special", {31'b0, out_special}, {31'b0, e.sp});
        chk("out_special_result", out_special_result, e.res);
        if (e.sp && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      end
    end
  end

  // Offer a pair; it is recorded as expected once in_ready is seen with it.
  task automatic push(input exp_t v);
    bit done = 0;
    in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(v);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout: got in_ready=0, expected 1 within 100 cycles");
    end
  endtask

  // Push into an empty FIFO with out_ready low and check the 1-cycle latency.
  task automatic push_first(input exp_t v);
    in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
    @(negedge clk);
    chk("no_bypass_out_valid", {31'b0, out_valid}, 32'd0);
    chk("first_in_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready) sb_q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("lat1_out_a", out_a, v.a);
    chk("lat1_out_b", out_b, v.b);
    chk("lat1_out_special", {31'b0, out_special}, {31'b0, v.sp});
  endtask

  task automatic drain();
    bit done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (sb_q.size() == 0 && !out_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d entries left, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // a, b, op, special, result -- all hand-derived
    vecs = '{
      '{32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000}, // inf - inf
      '{32'h7F800000, 32'hFF800000, 1'b1, 1'b1, 32'h7F800000}, // inf - (-inf)
      '{32'h00000000, 32'h40400000, 1'b1, 1'b1, 32'hC0400000}, // 0 - 3
      '{32'h80000000, 32'h00000000, 1'b1, 1'b1, 32'h80000000}, // -0 - 0
      '{32'h7F800001, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000}, // NaN a
      '{32'h3F800000, 32'h7F800000, 1'b1, 1'b1, 32'hFF800000}, // 1 - inf
      '{32'h40A00000, 32'h80000000, 1'b0, 1'b1, 32'h40A00000}, // 5 + -0
      '{32'h00000001, 32'h3F800000, 1'b0, 1'b1, 32'h3F800000}, // denorm + 1
      '{32'h00000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000}, // 0 + -0
      '{32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 32'h7FC00000}, // -inf + NaN
      '{32'hFF800000, 32'hFF800000, 1'b0, 1'b1, 32'hFF800000}, // -inf + -inf
      '{32'h40490FDB, 32'hC0000000, 1'b1, 1'b0, 32'h00000000}  // normal pair
    };

    // Reset state while rst is held
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_special_count", {16'b0, special_count}, 32'd0);
    chk("rst_out_special", {31'b0, out_special}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Normal pair into empty FIFO
    push_first('{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h0});
    drain();

    // Special-case classification table
    out_ready = 1'b1;
    foreach (vecs[i]) push(vecs[i]);
    drain();
    chk("sc_after_table", {16'b0, special_count}, {16'b0, exp_sc});
    chk("sc_after_table_abs", {16'b0, special_count}, 32'd11);

    // Fill to DEPTH with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push('{32'h41000000 + 32'(i), 32'h42000000 + 32'(i), 1'(i), 1'b0, 32'h0});
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("full_hold_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_hold_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_head_a", out_a, 32'h41000000);
    // Stream through the full FIFO across two pointer wraps
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      push('{32'h43000000 + 32'(i), 32'h44000000 + 32'(i), 1'(i), 1'b0, 32'h0});
    drain();

    // Asynchronous reset with 3 entries queued
    out_ready = 1'b0;
    push(vecs[0]);
    push(vecs[11]);
    push(vecs[2]);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_special_count", {16'b0, special_count}, 32'd0);
    chk("async_rst_out_special", {31'b0, out_special}, 32'd0);
    sb_q.delete();
    exp_sc = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    push_first(vecs[11]);
    drain();
    chk("sc_after_reset", {16'b0, special_count}, 32'd0);

    // Saturation of special_count
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) push(vecs[0]);
    drain();
    chk("sc_saturated", {16'b0, special_count}, 32'h0000FFFF);
    chk("sc_model", {16'b0, special_count}, {16'b0, exp_sc});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_operand_stage.md
FP_OPERAND_STAGE -- requirements
Module: fp_operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in IEEE 754 single-precision format.
REQ-002 The block SHALL have parameter EXP_BITS, default 8, exponent field width.
REQ-003 The block SHALL have parameter MANT_BITS, default 23, mantissa field width.
REQ-004 The block SHALL have parameter DEPTH, default 4, FIFO entries; legal values are powers of two, minimum 2.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, upstream operand pair valid.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a pair.
REQ-009 The block SHALL have ports in_a and in_b, input, WIDTH each, operands.
REQ-010 The block SHALL have port in_op, input, 1, operation select: 0 = a+b, 1 = a-b.
REQ-011 The block SHALL have port out_valid, output, 1, head entry valid toward the adder.
REQ-012 The block SHALL have port out_ready, input, 1, the adder side accepts the head entry.
REQ-013 The block SHALL have ports out_a, out_b (WIDTH) and out_op (1), outputs, head entry operands.
REQ-014 The block SHALL have port out_special, output, 1, head entry resolved without the adder.
REQ-015 The block SHALL have port out_special_result, output, WIDTH, bypass result, valid when out_special=1.
REQ-016 The block SHALL have port special_count, output, 16, saturating count of dequeued special entries.

Function
REQ-017 The block SHALL accept a push when in_valid && in_ready; in_ready = (count < DEPTH), combinational from registered count only.
REQ-018 The block SHALL pop when out_valid && out_ready; out_valid = (count != 0).
REQ-019 The block SHALL present the head entry on out_* directly from storage; a push into an empty FIFO appears on out_* one cycle later (latency 1, no bypass).
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; when full, in_ready=0, so no push occurs even if a pop happens that cycle.
REQ-021 The read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 The block SHALL classify each pair at push time and store out_special/out_special_result with the entry; classification uses effective sign of b, sb_eff = b[31] ^ in_op.
REQ-023 Classification SHALL use these definitions: NaN = exp all-ones, mant != 0; Inf = exp all-ones, mant == 0; zero = exp == 0 (denormals flushed to zero).
REQ-024 Priority 1: if either operand is NaN, or both are Inf with a[31] != sb_eff, then special=1 and result=0x7FC00000.
REQ-025 Priority 2: if a is Inf, then special=1 and result=a; else if b is Inf, then special=1 and result={sb_eff, b[30:0]}.
REQ-026 Priority 3: if both operands are zero, then special=1 and result={a[31] & sb_eff, 31'b0}.
REQ-027 Priority 4: if only a is zero, then special=1 and result={sb_eff, b[30:0]}; if only b is zero, then special=1 and result=a.
REQ-028 If none of the priority cases apply, special=0 and result=0; out_a, out_b and out_op SHALL always carry the unmodified inputs.
REQ-029 special_count SHALL increment on each pop with out_special=1 and SHALL hold at 0xFFFF.

Reset
REQ-030 While rst=1, and immediately on its assertion, count, pointers and special_count SHALL be 0, so out_valid=0 and in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be reset, but out_special SHALL read 0 while empty.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 Push a=0x3F800000, b=0x40000000, op=0 into the empty FIFO -> out_valid=1 the next cycle, out_a/out_b unchanged, out_special=0.
REQ-034 Push DEPTH pairs with out_ready=0 -> in_ready=0 after the 4th; then hold in_valid=1 with out_ready=1 -> one pop and one push per cycle, FIFO order preserved across pointer wrap.
REQ-035 Push a=0x7F800000, b=0x7F800000, op=1 -> out_special=1, result 0x7FC00000; push a=0x7F800000, b=0xFF800000, op=1 -> result 0x7F800000.
REQ-036 Push a=0x00000000, b=0x40400000, op=1 -> out_special=1, result 0xC0400000; push a=0x80000000, b=0x00000000, op=1 -> result 0x80000000.
REQ-037 Fill to 3 entries, then assert rst asynchronously between edges -> out_valid=0 and in_ready=1 at once, special_count=0.
REQ-038 Pop 65537 special entries -> special_count saturates at 0xFFFF.
